// File: rtl/cpu_pkg.sv
// Shared CPU-side types and helpers used by the hex_info_writer debug overlay.
package cpu_pkg;

    typedef enum logic [2:0] {
        HW_IDLE,
        HW_LOAD,
        HW_SCAN,
        HW_WRITE,
        HW_DONE
    } hex_writer_state_e;

    localparam logic [7:0] HEX_PREFIX_CHAR = 8'h24;

    function automatic logic [7:0] to_hexchar(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};
    endfunction

endpackage

// File: rtl/hex_nibble_sel.sv
// Picks the (ch, nib) nibble out of the snapshot and shadow vectors and
// reports whether the two are equal.
module hex_nibble_sel #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 16,
    parameter int CH_W   = 2,
    parameter int NIB_W  = 2
) (
    input  logic [NUM_CH*DATA_W-1:0] snapshot,
    input  logic [NUM_CH*DATA_W-1:0] shadow,
    input  logic [CH_W-1:0]          ch,
    input  logic [NIB_W-1:0]         nib,
    output logic [3:0]               snap_nib,
    output logic                     nib_eq
);

    localparam int NIB = DATA_W / 4;

    logic [3:0] shad_nib;

    // One-hot style mux over every channel/nibble slot.
    always_comb begin
        snap_nib = '0;
        shad_nib = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            for (int n = 0; n < NIB; n++) begin
                if (ch == CH_W'(k) && nib == NIB_W'(n)) begin
                    snap_nib = snapshot[k*DATA_W + n*4 +: 4];
                    shad_nib = shadow[k*DATA_W + n*4 +: 4];
                end
            end
        end
    end

    assign nib_eq = (snap_nib == shad_nib);

endmodule

// File: rtl/hex_info_writer.sv
// Debug-overlay hex dumper: snapshots NUM_CH channel registers and writes
// their uppercase hex characters into VRAM over a ready/valid port.
// Diff mode writes only nibbles that changed since the last completed dump.
// Optional build macro HEX_INFO_PREFIX_EN adds a '$' before each channel.
//
// state    | meaning
// HW_IDLE  | waiting for start; latches diff_mode
// HW_LOAD  | snapshot ch_data, reset the character index
// HW_SCAN  | evaluate current character: skip it or stage a write
// HW_WRITE | hold the staged write until vram_ready
// HW_DONE  | pulse done, copy snapshot into shadow
module hex_info_writer
    import cpu_pkg::*;
#(
    parameter int         NUM_CH    = 4,
    parameter int         DATA_W    = 16,
    parameter int         VRAM_AW   = 10,
    parameter logic [3:0] ATTR_NORM = 4'hF,
    parameter logic [3:0] ATTR_HI   = 4'hC
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      diff_mode,
    input  logic                      invalidate,
    input  logic [NUM_CH*DATA_W-1:0]  ch_data,
    input  logic [NUM_CH*VRAM_AW-1:0] ch_pos,
    output logic                      vram_we,
    output logic [VRAM_AW-1:0]        vram_addr,
    output logic [7:0]                vram_din,
    output logic [3:0]                vram_din_t,
    input  logic                      vram_ready,
    output logic                      busy,
    output logic                      done
);

`ifdef HEX_INFO_PREFIX_EN
    localparam bit PFX_EN = 1'b1;
`else
    localparam bit PFX_EN = 1'b0;
`endif

    localparam int NIB   = DATA_W / 4;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int NIB_W = (NIB > 1) ? $clog2(NIB) : 1;

    localparam logic [CH_W-1:0]    CH_LAST = CH_W'(NUM_CH - 1);
    localparam logic [NIB_W-1:0]   NIB_TOP = NIB_W'(NIB - 1);
    localparam logic [VRAM_AW-1:0] HEX_OFS = VRAM_AW'(PFX_EN);

    hex_writer_state_e state, state_nxt;

    logic                      diff_q;
    logic                      shadow_valid;
    logic [NUM_CH*DATA_W-1:0]  snapshot;
    logic [NUM_CH*DATA_W-1:0]  shadow;
    logic [CH_W-1:0]           ch;
    logic [NIB_W-1:0]          nib;
    logic                      pfx_mode;
    logic                      pfx_pend;
    logic                      pfx_cur;

    logic [3:0]                snap_nib;
    logic                      nib_eq;
    logic [VRAM_AW-1:0]        pos_sel;
    logic [VRAM_AW-1:0]        hex_addr;
    logic                      hi_mode;
    logic                      last_char;
    logic                      skip;
    logic [CH_W-1:0]           ch_adv;
    logic [NIB_W-1:0]          nib_adv;

    hex_nibble_sel #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .CH_W   (CH_W),
        .NIB_W  (NIB_W)
    ) u_sel (
        .snapshot (snapshot),
        .shadow   (shadow),
        .ch       (ch),
        .nib      (nib),
        .snap_nib (snap_nib),
        .nib_eq   (nib_eq)
    );

    // Start address of the channel currently being scanned.
    always_comb begin
        pos_sel = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch == CH_W'(k)) begin
                pos_sel = ch_pos[k*VRAM_AW +: VRAM_AW];
            end
        end
    end

    // Highlighting only applies when there is a valid previous dump to diff against.
    assign hi_mode   = diff_q & shadow_valid;
    assign last_char = (ch == CH_LAST) && (nib == '0);
    assign skip      = hi_mode && nib_eq && !pfx_pend;
    assign ch_adv    = (nib == '0) ? ch + CH_W'(1) : ch;
    assign nib_adv   = (nib == '0) ? NIB_TOP : nib - NIB_W'(1);
    // MS nibble goes to the lowest address; wraps modulo 2^VRAM_AW.
    assign hex_addr  = pos_sel + HEX_OFS + VRAM_AW'(NIB - 1) - VRAM_AW'(nib);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HW_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        state_nxt = state;
        busy      = (state != HW_IDLE);
        done      = (state == HW_DONE);
        vram_we   = (state == HW_WRITE);
        case (state)
            HW_IDLE: begin
                if (start) begin
                    state_nxt = HW_LOAD;
                end
            end
            HW_LOAD: begin
                state_nxt = HW_SCAN;
            end
            HW_SCAN: begin
                if (skip) begin
                    state_nxt = last_char ? HW_DONE : HW_SCAN;
                end else begin
                    state_nxt = HW_WRITE;
                end
            end
            HW_WRITE: begin
                if (vram_ready) begin
                    state_nxt = (!pfx_cur && last_char) ? HW_DONE : HW_SCAN;
                end
            end
            HW_DONE: begin
                state_nxt = HW_IDLE;
            end
            default: begin
                state_nxt = HW_IDLE;
            end
        endcase
    end

    // Datapath: snapshot/shadow, character index and the staged write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_q       <= 1'b0;
            shadow_valid <= 1'b0;
            snapshot     <= '0;
            shadow       <= '0;
            ch           <= '0;
            nib          <= '0;
            pfx_mode     <= 1'b0;
            pfx_pend     <= 1'b0;
            pfx_cur      <= 1'b0;
            vram_addr    <= '0;
            vram_din     <= '0;
            vram_din_t   <= '0;
        end else begin
            // invalidate wins over the end-of-dump set.
            if (invalidate) begin
                shadow_valid <= 1'b0;
            end else if (state == HW_DONE) begin
                shadow_valid <= 1'b1;
            end

            case (state)
                HW_IDLE: begin
                    if (start) begin
                        diff_q <= diff_mode;
                    end
                end
                HW_LOAD: begin
                    snapshot <= ch_data;
                    ch       <= '0;
                    nib      <= NIB_TOP;
                    pfx_mode <= PFX_EN && !hi_mode;
                    pfx_pend <= PFX_EN && !hi_mode;
                end
                HW_SCAN: begin
                    if (pfx_pend) begin
                        vram_addr  <= pos_sel;
                        vram_din   <= HEX_PREFIX_CHAR;
                        vram_din_t <= ATTR_NORM;
                        pfx_cur    <= 1'b1;
                    end else if (skip) begin
                        if (!last_char) begin
                            ch  <= ch_adv;
                            nib <= nib_adv;
                            if (nib == '0) begin
                                pfx_pend <= pfx_mode;
                            end
                        end
                    end else begin
                        vram_addr  <= hex_addr;
                        vram_din   <= to_hexchar(snap_nib);
                        vram_din_t <= hi_mode ? ATTR_HI : ATTR_NORM;
                        pfx_cur    <= 1'b0;
                    end
                end
                HW_WRITE: begin
                    if (vram_ready) begin
                        if (pfx_cur) begin
                            pfx_pend <= 1'b0;
                        end else if (!last_char) begin
                            ch  <= ch_adv;
                            nib <= nib_adv;
                            if (nib == '0) begin
                                pfx_pend <= pfx_mode;
                            end
                        end
                    end
                end
                HW_DONE: begin
                    shadow <= snapshot;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hex_info_writer.sv
module tb_hex_info_writer;

    localparam int         NUM_CH  = 2;
    localparam int         DATA_W  = 8;
    localparam int         VRAM_AW = 10;
    localparam int         NIB     = DATA_W / 4;
    localparam logic [3:0] A_NORM  = 4'hF;
    localparam logic [3:0] A_HI    = 4'hC;
`ifdef HEX_INFO_PREFIX_EN
    localparam bit PFX = 1'b1;
`else
    localparam bit PFX = 1'b0;
`endif

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      start;
    logic                      diff_mode;
    logic                      invalidate;
    logic [NUM_CH*DATA_W-1:0]  ch_data;
    logic [NUM_CH*VRAM_AW-1:0] ch_pos;
    logic                      vram_we;
    logic [VRAM_AW-1:0]        vram_addr;
    logic [7:0]                vram_din;
    logic [3:0]                vram_din_t;
    logic                      vram_ready;
    logic                      busy;
    logic                      done;

    hex_info_writer #(
        .NUM_CH    (NUM_CH),
        .DATA_W    (DATA_W),
        .VRAM_AW   (VRAM_AW),
        .ATTR_NORM (A_NORM),
        .ATTR_HI   (A_HI)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .diff_mode  (diff_mode),
        .invalidate (invalidate),
        .ch_data    (ch_data),
        .ch_pos     (ch_pos),
        .vram_we    (vram_we),
        .vram_addr  (vram_addr),
        .vram_din   (vram_din),
        .vram_din_t (vram_din_t),
        .vram_ready (vram_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef logic [VRAM_AW+8+4-1:0] wr_t;   // {addr, char, attr}

    wr_t              got_q[$];
    wr_t              exp_q[$];
    int               done_cnt;
    int               checks = 0;
    int               errors = 0;
    int               exp_cyc;
    int               last_cyc;
    logic [DATA_W-1:0] m_shadow [NUM_CH];
    bit               m_valid;

    // Completed handshakes and done pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (vram_we && vram_ready) got_q.push_back({vram_addr, vram_din, vram_din_t});
        if (done) done_cnt++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] v);
        if (v < 4'd10) return 8'd48 + 8'(v);
        return 8'd65 + 8'(v) - 8'd10;
    endfunction

    // Reference: list of writes and cycle count for one dump with ready held high.
    task automatic build_exp(input logic dm);
        bit hi;
        logic [DATA_W-1:0]  val;
        logic [VRAM_AW-1:0] base;
        logic [3:0]         nv, ov;
        exp_q.delete();
        exp_cyc = 2;
        hi = dm && m_valid;
        for (int k = 0; k < NUM_CH; k++) begin
            val  = ch_data[k*DATA_W +: DATA_W];
            base = ch_pos[k*VRAM_AW +: VRAM_AW];
            if (PFX && !hi) begin
                exp_q.push_back({base, 8'h24, A_NORM});
                exp_cyc += 2;
                base = base + 10'd1;
            end
            for (int i = 0; i < NIB; i++) begin
                nv = 4'(val >> (4 * (NIB - 1 - i)));
                ov = 4'(m_shadow[k] >> (4 * (NIB - 1 - i)));
                if (hi && nv == ov) begin
                    exp_cyc += 1;
                end else begin
                    exp_q.push_back({base + VRAM_AW'(i), hexc(nv), hi ? A_HI : A_NORM});
                    exp_cyc += 2;
                end
            end
        end
    endtask

    task automatic do_case(input logic dm, input int stall, input bit disturb, input bit inv_done);
        logic [NUM_CH*DATA_W-1:0] d0;
        wr_t hold;
        int  cyc;
        int  st;
        build_exp(dm);
        d0 = ch_data;
        st = stall;
        got_q.delete();
        done_cnt = 0;
        start = 1'b1;
        diff_mode = dm;
        tick;
        start = 1'b0;
        cyc = 1;
        if (st > 0) vram_ready = 1'b0;
        while (!done && cyc < 300) begin
            if (st > 0 && vram_we) begin
                hold = {vram_addr, vram_din, vram_din_t};
                for (int s = 0; s < st; s++) begin
                    tick;
                    cyc++;
                    chk("bp_we_held", 32'(vram_we), 32'd1);
                    chk("bp_data_held", 32'({vram_addr, vram_din, vram_din_t}), 32'(hold));
                end
                vram_ready = 1'b1;
                st = 0;
            end else begin
                if (disturb && cyc >= 2) begin
                    ch_data   = 16'($urandom);
                    start     = 1'($urandom_range(0, 1));
                    diff_mode = 1'($urandom_range(0, 1));
                end
                tick;
                cyc++;
            end
        end
        start = 1'b0;
        invalidate = inv_done;
        chk("done_timeout", 32'(cyc < 300), 32'd1);
        tick;
        invalidate = 1'b0;
        last_cyc = cyc;
        chk("done_count", 32'(done_cnt), 32'd1);
        chk("busy_after", 32'(busy), 32'd0);
        chk("write_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) chk("write_entry", 32'(got_q[i]), 32'(exp_q[i]));
        end
        chk("latency", 32'(cyc), 32'(exp_cyc + stall));
        for (int k = 0; k < NUM_CH; k++) m_shadow[k] = d0[k*DATA_W +: DATA_W];
        m_valid = !inv_done;
    endtask

    initial begin
        int w;
        rst_n = 1'b0;
        start = 1'b0;
        diff_mode = 1'b0;
        invalidate = 1'b0;
        ch_data = '0;
        ch_pos = '0;
        vram_ready = 1'b1;
        m_valid = 1'b0;
        for (int k = 0; k < NUM_CH; k++) m_shadow[k] = '0;
        tick;
        tick;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_we", 32'(vram_we), 32'd0);
        chk("rst_addr", 32'(vram_addr), 32'd0);
        chk("rst_din", 32'(vram_din), 32'd0);
        chk("rst_din_t", 32'(vram_din_t), 32'd0);
        rst_n = 1'b1;
        tick;

        // Full dump of the reference example.
        ch_data = {8'hF0, 8'h3A};
        ch_pos  = {10'd40, 10'd0};
        do_case(1'b0, 0, 1'b0, 1'b0);
        if (!PFX) begin
            chk("full_latency_abs", 32'(last_cyc), 32'd10);
            if (got_q.size() > 0) chk("full_first", 32'(got_q[0]), 32'({10'd0, 8'h33, 4'hF}));
        end

        // Diff dump with one changed nibble.
        ch_data = {8'hF0, 8'h3B};
        do_case(1'b1, 0, 1'b0, 1'b0);
        if (!PFX) begin
            chk("diff_latency_abs", 32'(last_cyc), 32'd7);
            if (got_q.size() > 0) chk("diff_write", 32'(got_q[0]), 32'({10'd1, 8'h42, 4'hC}));
        end

        // All-skipped diff dump still completes.
        do_case(1'b1, 0, 1'b0, 1'b0);

        // Backpressure on the first write.
        do_case(1'b0, 3, 1'b0, 1'b0);

        // invalidate between dumps forces a full, normal-attribute diff dump.
        invalidate = 1'b1;
        tick;
        invalidate = 1'b0;
        m_valid = 1'b0;
        do_case(1'b1, 0, 1'b0, 1'b0);

        // start pulses and data changes while busy.
        ch_data = {8'h5C, 8'hE7};
        do_case(1'b0, 0, 1'b1, 1'b0);

        // invalidate during DONE keeps shadow invalid.
        ch_data = {8'h5C, 8'hE7};
        do_case(1'b1, 0, 1'b0, 1'b1);
        do_case(1'b1, 0, 1'b0, 1'b0);

        // Address wrap with overlapping channels.
        ch_pos = {10'd1023, 10'd1022};
        ch_data = {8'h12, 8'h9D};
        do_case(1'b0, 0, 1'b0, 1'b0);

        // Reset in the middle of a stalled write.
        got_q.delete();
        vram_ready = 1'b0;
        start = 1'b1;
        diff_mode = 1'b0;
        tick;
        start = 1'b0;
        w = 0;
        while (!vram_we && w < 20) begin
            tick;
            w++;
        end
        chk("rst_reach_write", 32'(vram_we), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_we", 32'(vram_we), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_addr", 32'(vram_addr), 32'd0);
        tick;
        rst_n = 1'b1;
        vram_ready = 1'b1;
        tick;
        chk("midrst_no_write", 32'(got_q.size()), 32'd0);
        m_valid = 1'b0;
        do_case(1'b1, 0, 1'b0, 1'b0);

        // Randomised dumps.
        for (int r = 0; r < 12; r++) begin
            if ($urandom_range(0, 2) == 0) ch_data = 16'($urandom);
            else ch_data = ch_data ^ (16'h000F << (4 * $urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) ch_pos = 20'($urandom);
            if ($urandom_range(0, 4) == 0) begin
                invalidate = 1'b1;
                tick;
                invalidate = 1'b0;
                m_valid = 1'b0;
            end
            do_case(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? 2 : 0, 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
